// File: rtl/mcdf_slave_fifo_if.sv
// Channel-side and arbiter-side handshake of one MCDF slave FIFO.
// slave: the FIFO's view. master: the view of the channel/arbiter driving it.
interface mcdf_slave_fifo_if #(
    parameter int DWIDTH = 32
);
    logic [DWIDTH-1:0] ch_data;
    logic              ch_valid;
    logic              ch_ready;
    logic              slv_req;
    logic [1:0]        slv_prio;
    logic              a2s_ack;
    logic [DWIDTH-1:0] slv_data;
    logic              slv_val;

    modport slave (
        input  ch_data,
        input  ch_valid,
        input  a2s_ack,
        output ch_ready,
        output slv_req,
        output slv_prio,
        output slv_data,
        output slv_val
    );

    modport master (
        output ch_data,
        output ch_valid,
        output a2s_ack,
        input  ch_ready,
        input  slv_req,
        input  slv_prio,
        input  slv_data,
        input  slv_val
    );
endinterface

// File: rtl/mcdf_slave_fifo.sv
// MCDF per-channel input FIFO: buffers channel words, requests the arbiter
// once a packet's worth is stored, and pops one word per acknowledge.
module mcdf_slave_fifo #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 32,
    parameter int AWIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              chnl_en,
    input  logic [1:0]        slv_prio_i,
    input  logic [5:0]        pkt_len,
    output logic [AWIDTH:0]   margin,
    mcdf_slave_fifo_if.slave  bus
);

    localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH + 1)'(DEPTH);
    localparam logic [6:0]      DEPTH_L = 7'(DEPTH);

    logic [DWIDTH-1:0] mem_q [DEPTH];

    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   count_q, count_d;
    logic [DWIDTH-1:0] slv_data_q, slv_data_d;
    logic              slv_val_q, slv_val_d;
    logic [1:0]        slv_prio_q;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [6:0]        len_ext;
    logic [6:0]        eff_len;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // Push is decided against the registered count only, so a same-cycle pop
    // at full never opens a slot for the incoming word.
    assign push = bus.ch_valid && bus.ch_ready;
    assign pop  = bus.a2s_ack && !empty && chnl_en;

    always_comb begin
        len_ext = {1'b0, pkt_len};
        if (pkt_len == '0) begin
            eff_len = 7'd1;
        end else if (len_ext > DEPTH_L) begin
            eff_len = DEPTH_L;
        end else begin
            eff_len = len_ext;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        slv_data_d = slv_data_q;
        slv_val_d  = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AWIDTH'(1);
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + AWIDTH'(1);
            slv_data_d = mem_q[rd_ptr_q];
            slv_val_d  = 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + (AWIDTH + 1)'(1);
            2'b01:   count_d = count_q - (AWIDTH + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            slv_data_q <= '0;
            slv_val_q  <= 1'b0;
            slv_prio_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            slv_data_q <= slv_data_d;
            slv_val_q  <= slv_val_d;
            slv_prio_q <= slv_prio_i;
        end
    end

    // Storage carries no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.ch_data;
        end
    end

    // ready/req are held low while reset is asserted, independent of chnl_en.
    assign bus.ch_ready = rstn && chnl_en && !full;
    assign bus.slv_req  = rstn && chnl_en && (7'(count_q) >= eff_len);
    assign bus.slv_prio = slv_prio_q;
    assign bus.slv_data = slv_data_q;
    assign bus.slv_val  = slv_val_q;
    assign margin       = DEPTH_C - count_q;

endmodule

// File: tb/tb_mcdf_slave_fifo.sv
// Directed bench for mcdf_slave_fifo: vector table plus hand sequences for
// full, random wrap, channel disable and mid-stream reset.
module tb_mcdf_slave_fifo;

    logic       clk;
    logic       rstn;
    logic       chnl_en;
    logic [1:0] slv_prio_i;
    logic [5:0] pkt_len;
    logic [5:0] margin;

    int checks = 0;
    int errors = 0;

    mcdf_slave_fifo_if #(.DWIDTH(32)) bus_if ();

    mcdf_slave_fifo #(.DWIDTH(32), .DEPTH(32)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .chnl_en    (chnl_en),
        .slv_prio_i (slv_prio_i),
        .pkt_len    (pkt_len),
        .margin     (margin),
        .bus        (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        valid;
        logic [31:0] data;
        logic        ack;
        logic [5:0]  len;
        logic        e_ready;
        logic        e_req;
        logic [5:0]  e_margin;
        logic        e_val;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic en, input logic valid, input logic [31:0] data,
                           input logic ack, input logic [5:0] len,
                           input logic e_ready, input logic e_req, input logic [5:0] e_margin,
                           input logic e_val, input logic [31:0] e_data);
        vec_t v;
        v.en = en; v.valid = valid; v.data = data; v.ack = ack; v.len = len;
        v.e_ready = e_ready; v.e_req = e_req; v.e_margin = e_margin;
        v.e_val = e_val; v.e_data = e_data;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int           cnt;
        int           pushed;
        int           cycles;
        logic         p_push;
        logic         p_pop;
        logic [31:0]  p_data;
        logic [31:0]  model_q[$];

        rstn = 1'b0;
        chnl_en = 1'b1;
        slv_prio_i = 2'd2;
        pkt_len = 6'd4;
        bus_if.ch_data = '0;
        bus_if.ch_valid = 1'b0;
        bus_if.a2s_ack = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus_if.ch_ready), 32'd0);
        chk("rst_req", 32'(bus_if.slv_req), 32'd0);
        chk("rst_prio", 32'(bus_if.slv_prio), 32'd0);
        chk("rst_data", bus_if.slv_data, 32'd0);
        chk("rst_val", 32'(bus_if.slv_val), 32'd0);
        chk("rst_margin", 32'(margin), 32'd32);
        @(negedge clk);
        rstn = 1'b1;
        step();
        chk("prio_reg0", 32'(bus_if.slv_prio), 32'd2);
        slv_prio_i = 2'd1;
        #1;
        chk("prio_hold", 32'(bus_if.slv_prio), 32'd2);
        step();
        chk("prio_reg1", 32'(bus_if.slv_prio), 32'd1);
        chk("margin_init", 32'(margin), 32'd32);

        // Vector table: {en, valid, data, ack, len} -> {ready, req, margin, val, data}
        add_vec(1, 1, 32'h11, 0, 4,  1, 0, 31, 0, 32'h0);
        add_vec(1, 1, 32'h12, 0, 4,  1, 0, 30, 0, 32'h0);
        add_vec(1, 1, 32'h13, 0, 4,  1, 0, 29, 0, 32'h0);
        add_vec(1, 1, 32'h14, 0, 4,  1, 1, 28, 0, 32'h0);
        add_vec(1, 0, 32'h0,  1, 4,  1, 0, 29, 1, 32'h11);
        add_vec(1, 0, 32'h0,  1, 4,  1, 0, 30, 1, 32'h12);
        add_vec(1, 0, 32'h0,  1, 4,  1, 0, 31, 1, 32'h13);
        add_vec(1, 0, 32'h0,  1, 4,  1, 0, 32, 1, 32'h14);
        add_vec(1, 0, 32'h0,  1, 4,  1, 0, 32, 0, 32'h14);
        add_vec(1, 0, 32'h0,  0, 4,  1, 0, 32, 0, 32'h14);
        add_vec(1, 1, 32'hA0, 0, 0,  1, 1, 31, 0, 32'h14);
        add_vec(1, 1, 32'hA1, 0, 4,  1, 0, 30, 0, 32'h14);
        add_vec(1, 1, 32'hA2, 0, 4,  1, 0, 29, 0, 32'h14);
        add_vec(1, 1, 32'hA3, 0, 4,  1, 1, 28, 0, 32'h14);
        add_vec(1, 1, 32'hB0, 1, 4,  1, 1, 28, 1, 32'hA0);
        add_vec(1, 0, 32'h0,  1, 40, 1, 0, 29, 1, 32'hA1);
        add_vec(1, 0, 32'h0,  1, 4,  1, 0, 30, 1, 32'hA2);
        add_vec(1, 0, 32'h0,  1, 4,  1, 0, 31, 1, 32'hA3);
        add_vec(1, 0, 32'h0,  1, 4,  1, 0, 32, 1, 32'hB0);
        add_vec(1, 0, 32'h0,  1, 4,  1, 0, 32, 0, 32'hB0);
        add_vec(0, 1, 32'hC0, 1, 4,  0, 0, 32, 0, 32'hB0);

        foreach (vecs[i]) begin
            chnl_en = vecs[i].en;
            bus_if.ch_valid = vecs[i].valid;
            bus_if.ch_data = vecs[i].data;
            bus_if.a2s_ack = vecs[i].ack;
            pkt_len = vecs[i].len;
            step();
            chk($sformatf("vec%0d_ready", i), 32'(bus_if.ch_ready), 32'(vecs[i].e_ready));
            chk($sformatf("vec%0d_req", i), 32'(bus_if.slv_req), 32'(vecs[i].e_req));
            chk($sformatf("vec%0d_margin", i), 32'(margin), 32'(vecs[i].e_margin));
            chk($sformatf("vec%0d_val", i), 32'(bus_if.slv_val), 32'(vecs[i].e_val));
            chk($sformatf("vec%0d_data", i), bus_if.slv_data, vecs[i].e_data);
        end

        // Fill to full with valid held, then push+ack together at full
        chnl_en = 1'b1;
        pkt_len = 6'd40;
        bus_if.a2s_ack = 1'b0;
        bus_if.ch_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus_if.ch_data = 32'h100 + 32'(i);
            step();
            chk($sformatf("fill%0d_margin", i), 32'(margin), 32'(31 - i));
            chk($sformatf("fill%0d_ready", i), 32'(bus_if.ch_ready), 32'(i != 31));
            chk($sformatf("fill%0d_req", i), 32'(bus_if.slv_req), 32'(i == 31));
        end
        bus_if.ch_data = 32'hDEAD;
        step();
        chk("full_margin", 32'(margin), 32'd0);
        chk("full_ready", 32'(bus_if.ch_ready), 32'd0);
        bus_if.a2s_ack = 1'b1;
        step();
        chk("fullpp_margin", 32'(margin), 32'd1);
        chk("fullpp_val", 32'(bus_if.slv_val), 32'd1);
        chk("fullpp_data", bus_if.slv_data, 32'h100);
        chk("fullpp_ready", 32'(bus_if.ch_ready), 32'd1);
        bus_if.ch_valid = 1'b0;
        for (int i = 1; i < 32; i++) begin
            step();
            chk($sformatf("drain%0d_data", i), bus_if.slv_data, 32'h100 + 32'(i));
            chk($sformatf("drain%0d_val", i), 32'(bus_if.slv_val), 32'd1);
        end
        step();
        chk("drained_val", 32'(bus_if.slv_val), 32'd0);
        chk("drained_margin", 32'(margin), 32'd32);

        // Random valid/ack over 100 words with pkt_len=0, scoreboard model
        pkt_len = 6'd0;
        cnt = 0;
        pushed = 0;
        cycles = 0;
        while ((pushed < 100 || cnt > 0) && cycles < 3000) begin
            bus_if.ch_valid = (pushed < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus_if.a2s_ack = 1'($urandom_range(0, 1));
            bus_if.ch_data = 32'h5000_0000 + 32'(pushed);
            p_push = bus_if.ch_valid && (cnt != 32);
            p_pop = bus_if.a2s_ack && (cnt != 0);
            p_data = p_pop ? model_q[0] : 32'h0;
            step();
            cycles++;
            if (p_pop) begin
                void'(model_q.pop_front());
                cnt--;
            end
            if (p_push) begin
                model_q.push_back(32'h5000_0000 + 32'(pushed));
                pushed++;
                cnt++;
            end
            chk("rnd_val", 32'(bus_if.slv_val), 32'(p_pop));
            if (p_pop) chk("rnd_data", bus_if.slv_data, p_data);
            chk("rnd_margin", 32'(margin), 32'(32 - cnt));
            chk("rnd_req", 32'(bus_if.slv_req), 32'(cnt >= 1));
            chk("rnd_ready", 32'(bus_if.ch_ready), 32'(cnt != 32));
        end
        chk("rnd_complete", 32'(pushed == 100 && cnt == 0), 32'd1);
        bus_if.ch_valid = 1'b0;
        bus_if.a2s_ack = 1'b0;

        // Channel disable with 5 words buffered, ack held
        pkt_len = 6'd4;
        bus_if.ch_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_if.ch_data = 32'hE0 + 32'(i);
            step();
        end
        bus_if.ch_valid = 1'b0;
        chk("pre_dis_margin", 32'(margin), 32'd27);
        chnl_en = 1'b0;
        bus_if.a2s_ack = 1'b1;
        #1;
        chk("dis_ready", 32'(bus_if.ch_ready), 32'd0);
        chk("dis_req", 32'(bus_if.slv_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("dis%0d_val", i), 32'(bus_if.slv_val), 32'd0);
            chk($sformatf("dis%0d_margin", i), 32'(margin), 32'd27);
        end
        chnl_en = 1'b1;
        #1;
        chk("reen_req", 32'(bus_if.slv_req), 32'd1);
        chk("reen_ready", 32'(bus_if.ch_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("reen%0d_data", i), bus_if.slv_data, 32'hE0 + 32'(i));
            chk($sformatf("reen%0d_val", i), 32'(bus_if.slv_val), 32'd1);
            chk($sformatf("reen%0d_margin", i), 32'(margin), 32'(28 + i));
        end
        bus_if.a2s_ack = 1'b0;

        // Reset mid-stream with 10 words buffered and a pop just completed
        bus_if.ch_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus_if.ch_data = 32'hF0 + 32'(i);
            step();
        end
        bus_if.ch_valid = 1'b0;
        bus_if.a2s_ack = 1'b1;
        step();
        chk("prerst_val", 32'(bus_if.slv_val), 32'd1);
        chk("prerst_margin", 32'(margin), 32'd23);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_margin", 32'(margin), 32'd32);
        chk("midrst_val", 32'(bus_if.slv_val), 32'd0);
        chk("midrst_ready", 32'(bus_if.ch_ready), 32'd0);
        chk("midrst_req", 32'(bus_if.slv_req), 32'd0);
        chk("midrst_data", bus_if.slv_data, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("postrst%0d_val", i), 32'(bus_if.slv_val), 32'd0);
            chk($sformatf("postrst%0d_margin", i), 32'(margin), 32'd32);
        end
        bus_if.a2s_ack = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
